// File: rtl/flt_blocking_pattern_seq.sv
// Programmable per-channel handshake blocking-pattern sequencer with a writable pattern table.
// Optional LFSR pattern source is enabled by defining BLK_PAT_LFSR_EN (adds the lfsr_mode input).
module flt_blocking_pattern_seq #(
    parameter int unsigned       NUM_CH      = 5,
    parameter int unsigned       DEPTH       = 32,
    parameter int unsigned       ADDR_W      = 5,
    parameter logic [NUM_CH-1:0] DEFAULT_PAT = NUM_CH'(1),
    parameter logic [15:0]       LFSR_SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [NUM_CH-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              step_en,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] seq_len,
`ifdef BLK_PAT_LFSR_EN
    input  logic              lfsr_mode,
`endif
    output logic [NUM_CH-1:0] pat_out,
    output logic              pat_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [15:0]       loop_cnt
);

    localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    if (LFSR_SEED == 16'h0 || NUM_CH < 1 || NUM_CH > 16 || DEPTH > (2 ** ADDR_W)) begin : g_bad_cfg
        $error("flt_blocking_pattern_seq: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_n;
    logic [NUM_CH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic [NUM_CH-1:0] rd_data, step_pat, pat_n;
    logic              pat_valid_n;
    logic [ADDR_W-1:0] addr_n;
    logic [15:0]       cnt_n;
    logic [ADDR_W:0]   len, len_n, len_eff;
    logic              last, wr_ok;
    logic [15:0]       lfsr, lfsr_n, lfsr_adv;

    assign wr_ok    = wr_en && ({1'b0, wr_addr} < DEPTH_V);
    assign rd_data  = ent_valid[cur_addr[IDX_W-1:0]] ? mem[cur_addr[IDX_W-1:0]] : DEFAULT_PAT;
    assign len_eff  = (seq_len == '0 || {1'b0, seq_len} > DEPTH_V) ? DEPTH_V : {1'b0, seq_len};
    assign last     = ({1'b0, cur_addr} == len - 1'b1);
    assign lfsr_adv = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`ifdef BLK_PAT_LFSR_EN
    assign step_pat = lfsr_mode ? lfsr[NUM_CH-1:0] : rd_data;
`else
    assign step_pat = rd_data;
`endif

    // Nonblocking write keeps a same-cycle playback read on the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid <= '0;
        end else if (wr_ok) begin
            ent_valid[wr_addr[IDX_W-1:0]] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pat_out   <= '0;
            pat_valid <= 1'b0;
            cur_addr  <= '0;
            loop_cnt  <= '0;
            len       <= '0;
            lfsr      <= LFSR_SEED;
        end else begin
            state     <= state_n;
            pat_out   <= pat_n;
            pat_valid <= pat_valid_n;
            cur_addr  <= addr_n;
            loop_cnt  <= cnt_n;
            len       <= len_n;
            lfsr      <= lfsr_n;
        end
    end

    // The final one-shot entry stays visible for the first DONE cycle; the drain value follows.
    always_comb begin
        state_n     = state;
        pat_n       = pat_out;
        pat_valid_n = pat_valid;
        addr_n      = cur_addr;
        cnt_n       = loop_cnt;
        len_n       = len;
        lfsr_n      = lfsr;
        case (state)
            IDLE, DONE: begin
                pat_n       = (state == DONE) ? '1 : '0;
                pat_valid_n = 1'b0;
                if (stop) begin
                    state_n = IDLE;
                    pat_n   = '0;
                end else if (start) begin
                    state_n = RUN;
                    pat_n   = '0;
                    addr_n  = '0;
                    cnt_n   = '0;
                    len_n   = len_eff;
                    lfsr_n  = LFSR_SEED;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n     = IDLE;
                    pat_n       = '0;
                    pat_valid_n = 1'b0;
                    addr_n      = '0;
                end else if (start) begin
                    pat_valid_n = 1'b0;
                    addr_n      = '0;
                    cnt_n       = '0;
                    len_n       = len_eff;
                    lfsr_n      = LFSR_SEED;
                end else if (step_en) begin
                    pat_n       = step_pat;
                    pat_valid_n = 1'b1;
                    lfsr_n      = lfsr_adv;
                    if (!last) begin
                        addr_n = cur_addr + 1'b1;
                    end else if (loop_en) begin
                        addr_n = '0;
                        cnt_n  = (loop_cnt == 16'hFFFF) ? loop_cnt : loop_cnt + 16'd1;
                    end else begin
                        addr_n  = '0;
                        state_n = DONE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_flt_blocking_pattern_seq.sv
// Scoreboard bench for flt_blocking_pattern_seq; LFSR case built only with BLK_PAT_LFSR_EN.
module tb_flt_blocking_pattern_seq;

    localparam int NCH = 5;
    localparam int DEP = 32;
    localparam int AW  = 6;

    logic           clk = 1'b0;
    logic           rst, wr_en, start, stop, step_en, loop_en, lfsr_mode;
    logic [AW-1:0]  wr_addr, seq_len;
    logic [NCH-1:0] wr_data;
    logic [NCH-1:0] pat_out;
    logic           pat_valid, busy, done;
    logic [AW-1:0]  cur_addr;
    logic [15:0]    loop_cnt;

    flt_blocking_pattern_seq #(
        .NUM_CH(NCH), .DEPTH(DEP), .ADDR_W(AW),
        .DEFAULT_PAT(5'b00001), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .step_en(step_en), .loop_en(loop_en), .seq_len(seq_len),
`ifdef BLK_PAT_LFSR_EN
        .lfsr_mode(lfsr_mode),
`endif
        .pat_out(pat_out), .pat_valid(pat_valid), .busy(busy), .done(done),
        .cur_addr(cur_addr), .loop_cnt(loop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [NCH-1:0] m_tbl [DEP];
    bit             m_wr  [DEP];
    int             m_addr, m_len, m_loops, m_st;  // m_st: 0 idle, 1 run, 2 done
    bit             m_lmode;
    logic [15:0]    m_lfsr;
    logic [NCH-1:0] m_last;
    logic [NCH-1:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH-1:0] m_entry(input int a);
        return m_wr[a] ? m_tbl[a] : 5'b00001;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_pat"},   pat_out, 0);
        check({tag, "_valid"}, pat_valid, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < DEP; i++) m_wr[i] = 1'b0;
        m_st = 0; m_addr = 0; m_loops = 0;
        check_idle("reset");
        check("reset_addr", cur_addr, 0);
        check("reset_loops", loop_cnt, 0);
    endtask

    task automatic wr(input int a, input logic [NCH-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        if (a < DEP) begin m_tbl[a] = d; m_wr[a] = 1'b1; end
    endtask

    task automatic do_start(input int sl, input bit lp);
        seq_len = AW'(sl); loop_en = lp; start = 1'b1;
        tick();
        start = 1'b0;
        m_len = (sl == 0 || sl > DEP) ? DEP : sl;
        m_addr = 0; m_loops = 0; m_st = 1; m_lfsr = 16'hACE1;
        check("start_busy", busy, 1);
        check("start_addr", cur_addr, 0);
        check("start_loops", loop_cnt, 0);
    endtask

    task automatic do_step(input bit w, input int wa, input logic [NCH-1:0] wd);
        sb.push_back(m_lmode ? m_lfsr[NCH-1:0] : m_entry(m_addr));
        step_en = 1'b1;
        if (w) begin wr_en = 1'b1; wr_addr = AW'(wa); wr_data = wd; end
        tick();
        step_en = 1'b0; wr_en = 1'b0;
        if (w && wa < DEP) begin m_tbl[wa] = wd; m_wr[wa] = 1'b1; end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        if (m_addr != m_len - 1) m_addr++;
        else if (loop_en) begin m_addr = 0; m_loops++; end
        else m_st = 2;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            m_last = sb.pop_front();
            check("pat", pat_out, m_last);
        end
        check("busy", busy, m_st == 1);
        check("done", done, m_st == 2);
        if (m_st == 1) begin
            check("valid", pat_valid, 1);
            check("addr", cur_addr, m_addr);
        end
        check("loops", loop_cnt, m_loops);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        {rst, wr_en, start, stop, step_en, loop_en, lfsr_mode} = '0;
        wr_addr = '0; seq_len = '0; wr_data = '0; m_lmode = 1'b0;
        do_reset();

        // unwritten table, one-shot of 3, then drain
        do_start(3, 0);
        repeat (3) do_step(0, 0, 0);
        tick();
        check("drain_pat", pat_out, 5'b11111);
        check("drain_valid", pat_valid, 0);
        check("drain_done", done, 1);

        // looping sequence, restarted from DONE
        wr(0, 5'b01011); wr(1, 5'b10101); wr(2, 5'b01101);
        do_start(3, 1);
        repeat (7) do_step(0, 0, 0);
        check("loop2", loop_cnt, 2);

        // step_en low holds everything
        repeat (4) tick();
        check("hold_pat", pat_out, m_last);
        check("hold_addr", cur_addr, m_addr);
        check("hold_valid", pat_valid, 1);
        repeat (3) do_step(0, 0, 0);

        // stop beats step at cur_addr==1
        check("pre_stop_addr", cur_addr, 1);
        stop = 1'b1; step_en = 1'b1;
        tick();
        stop = 1'b0; step_en = 1'b0; m_st = 0;
        check_idle("stop");
        do_start(3, 1);
        do_step(0, 0, 0);

        // write entry 1 while it is played, then an out-of-range write aliasing entry 0
        do_step(1, 1, 5'b11000);
        do_step(0, 0, 0);
        do_step(0, 0, 0);
        do_step(0, 0, 0);
        wr(DEP, 5'b11111);
        repeat (3) do_step(0, 0, 0);

        // seq_len 0 -> full table one-shot; seq_len beyond table -> full table looping
        do_start(0, 0);
        repeat (DEP) do_step(0, 0, 0);
        do_start(40, 1);
        repeat (DEP + 1) do_step(0, 0, 0);

        // len 1 looping counts every step; start in RUN restarts
        do_start(1, 1);
        repeat (3) do_step(0, 0, 0);
        do_start(3, 1);
        do_step(0, 0, 0);

        // reset mid-run clears written entries
        do_reset();
        do_start(3, 0);
        repeat (3) do_step(0, 0, 0);

`ifdef BLK_PAT_LFSR_EN
        lfsr_mode = 1'b1; m_lmode = 1'b1;
        do_start(4, 0);
        repeat (4) do_step(0, 0, 0);
        lfsr_mode = 1'b0; m_lmode = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
